// File: rtl/fifo_ctrl_if.sv
// Handshake and memory-control bundle between FIFO producer/consumer logic and fifo_ctrl.
interface fifo_ctrl_if #(
  parameter int unsigned AW = 3
);
  logic          push_i;
  logic          pop_i;
  logic          flush_i;
  logic          mem_wr_en_o;
  logic [AW-1:0] mem_wr_addr_o;
  logic          mem_rd_en_o;
  logic [AW-1:0] mem_rd_addr_o;
  logic          rd_valid_o;
  logic          full_o;
  logic          empty_o;
  logic [AW:0]   count_o;
  logic          overflow_o;
  logic          underflow_o;
  logic          almost_full_o;
  logic          almost_empty_o;

  modport master (
    output push_i, pop_i, flush_i,
    input  mem_wr_en_o, mem_wr_addr_o, mem_rd_en_o, mem_rd_addr_o, rd_valid_o,
    input  full_o, empty_o, count_o, overflow_o, underflow_o,
    input  almost_full_o, almost_empty_o
  );

  modport slave (
    input  push_i, pop_i, flush_i,
    output mem_wr_en_o, mem_wr_addr_o, mem_rd_en_o, mem_rd_addr_o, rd_valid_o,
    output full_o, empty_o, count_o, overflow_o, underflow_o,
    output almost_full_o, almost_empty_o
  );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO controller sequencing an external dual-port memory: pointers, occupancy, flags, read-valid.
// Optional almost-full/almost-empty flags enabled by defining FIFO_CTRL_ALMOST_EN.
module fifo_ctrl #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2
) (
  input logic        clk,
  input logic        rst_i,
  fifo_ctrl_if.slave bus
);
  localparam int unsigned CW = AW + 1;

  // Elaboration-time sanity check on the configuration.
  if (DEPTH != (1 << AW) || AF_THRESH > DEPTH || AE_THRESH > DEPTH) begin : g_param_chk
    $error("fifo_ctrl: DEPTH must equal 2**AW and thresholds must not exceed DEPTH");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic full, empty, acc_gate, wr_acc, rd_acc;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  // No accept while in reset or flushing, so the memory enables stay low.
  assign acc_gate = ~rst_i & ~bus.flush_i;
  assign wr_acc   = acc_gate & bus.push_i & (~full | bus.pop_i);
  assign rd_acc   = acc_gate & bus.pop_i & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      rd_valid_d  = rd_acc;
      overflow_d  = overflow_q | (bus.push_i & full & ~bus.pop_i);
      underflow_d = underflow_q | (bus.pop_i & empty);
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.mem_wr_en_o   = wr_acc;
  assign bus.mem_wr_addr_o = wr_ptr_q;
  assign bus.mem_rd_en_o   = rd_acc;
  assign bus.mem_rd_addr_o = rd_ptr_q;
  assign bus.rd_valid_o    = rd_valid_q;
  assign bus.full_o        = full;
  assign bus.empty_o       = empty;
  assign bus.count_o       = count_q;
  assign bus.overflow_o    = overflow_q;
  assign bus.underflow_o   = underflow_q;

`ifdef FIFO_CTRL_ALMOST_EN
  assign bus.almost_full_o  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty_o = (count_q <= CW'(AE_THRESH));
`else
  assign bus.almost_full_o  = 1'b0;
  assign bus.almost_empty_o = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl (default build or with FIFO_CTRL_ALMOST_EN).
module tb_fifo_ctrl;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;
`ifdef FIFO_CTRL_ALMOST_EN
  localparam int ALM = 1;
`else
  localparam int ALM = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fifo_ctrl_if #(.AW(AW)) bus ();

  fifo_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .AF_THRESH(6), .AE_THRESH(2)
  ) u_dut (
    .clk   (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs mid-cycle; returns just after, leaving time to sample before the next rising edge.
  task automatic drive(input logic p, input logic q, input logic f);
    @(negedge clk);
    bus.push_i  = p;
    bus.pop_i   = q;
    bus.flush_i = f;
    #1;
  endtask

  initial begin
    bus.push_i  = 1'b1;
    bus.pop_i   = 1'b0;
    bus.flush_i = 1'b0;
    #3;
    // 1. reset state, enables gated while reset held
    check("rst_empty", 32'(bus.empty_o), 1);
    check("rst_full", 32'(bus.full_o), 0);
    check("rst_count", 32'(bus.count_o), 0);
    check("rst_wr_en", 32'(bus.mem_wr_en_o), 0);
    check("rst_rd_en", 32'(bus.mem_rd_en_o), 0);
    check("rst_rd_valid", 32'(bus.rd_valid_o), 0);
    check("rst_ovf", 32'(bus.overflow_o), 0);
    check("rst_udf", 32'(bus.underflow_o), 0);
    check("rst_afull", 32'(bus.almost_full_o), 0);
    check("rst_aempty", 32'(bus.almost_empty_o), ALM);
    @(negedge clk);
    rst = 1'b0;
    bus.push_i = 1'b0;

    // 2. fill to full, then one refused push
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0);
      check("fill_wr_en", 32'(bus.mem_wr_en_o), 1);
      check("fill_wr_addr", 32'(bus.mem_wr_addr_o), i);
      check("fill_count", 32'(bus.count_o), i);
    end
    drive(1, 0, 0);
    check("full_flag", 32'(bus.full_o), 1);
    check("ovf_push_wr_en", 32'(bus.mem_wr_en_o), 0);
    drive(0, 0, 0);
    check("ovf_set", 32'(bus.overflow_o), 1);
    check("ovf_count", 32'(bus.count_o), 8);

    // 3. drain with read-valid one cycle behind each pop, then one refused pop
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0);
      check("drain_rd_en", 32'(bus.mem_rd_en_o), 1);
      check("drain_rd_addr", 32'(bus.mem_rd_addr_o), i);
      check("drain_rd_valid", 32'(bus.rd_valid_o), (i > 0) ? 1 : 0);
    end
    drive(0, 1, 0);
    check("last_rd_valid", 32'(bus.rd_valid_o), 1);
    check("drained_empty", 32'(bus.empty_o), 1);
    check("udf_pop_rd_en", 32'(bus.mem_rd_en_o), 0);
    drive(0, 0, 0);
    check("udf_set", 32'(bus.underflow_o), 1);
    check("udf_rd_valid", 32'(bus.rd_valid_o), 0);
    check("ovf_sticky", 32'(bus.overflow_o), 1);
    drive(0, 0, 1);
    drive(0, 0, 0);
    check("flush_ovf_clr", 32'(bus.overflow_o), 0);
    check("flush_udf_clr", 32'(bus.underflow_o), 0);

    // 4. push 5, pop 5, push 6 across the wrap
    for (int i = 0; i < 5; i++) drive(1, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0);
      check("wrap_wr_addr", 32'(bus.mem_wr_addr_o), (5 + i) % 8);
    end
    drive(0, 0, 0);
    check("wrap_count", 32'(bus.count_o), 6);
    check("wrap_afull", 32'(bus.almost_full_o), ALM);
    check("wrap_aempty", 32'(bus.almost_empty_o), 0);

    // 5. simultaneous push+pop when full, then when empty
    drive(1, 0, 0);
    drive(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0);
      check("fullpp_wr_en", 32'(bus.mem_wr_en_o), 1);
      check("fullpp_rd_en", 32'(bus.mem_rd_en_o), 1);
      check("fullpp_wr_addr", 32'(bus.mem_wr_addr_o), 5 + i);
      check("fullpp_rd_addr", 32'(bus.mem_rd_addr_o), 5 + i);
      check("fullpp_count", 32'(bus.count_o), 8);
    end
    drive(0, 0, 0);
    check("fullpp_count_end", 32'(bus.count_o), 8);
    check("fullpp_no_ovf", 32'(bus.overflow_o), 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 0);
    drive(1, 1, 0);
    check("emptypp_wr_en", 32'(bus.mem_wr_en_o), 1);
    check("emptypp_rd_en", 32'(bus.mem_rd_en_o), 0);
    drive(0, 0, 0);
    check("emptypp_count", 32'(bus.count_o), 1);
    check("emptypp_udf", 32'(bus.underflow_o), 1);
    check("emptypp_empty", 32'(bus.empty_o), 0);

    // 6. flush beats push at count 4 with overflow set
    drive(0, 0, 1);
    for (int i = 0; i < 9; i++) drive(1, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0);
    drive(1, 0, 1);
    check("flush_wr_en", 32'(bus.mem_wr_en_o), 0);
    check("flush_rd_en", 32'(bus.mem_rd_en_o), 0);
    check("preflush_count", 32'(bus.count_o), 4);
    check("preflush_ovf", 32'(bus.overflow_o), 1);
    check("preflush_rd_valid", 32'(bus.rd_valid_o), 1);
    drive(0, 0, 0);
    check("postflush_count", 32'(bus.count_o), 0);
    check("postflush_ovf", 32'(bus.overflow_o), 0);
    check("postflush_wr_addr", 32'(bus.mem_wr_addr_o), 0);
    check("postflush_rd_addr", 32'(bus.mem_rd_addr_o), 0);
    check("postflush_rd_valid", 32'(bus.rd_valid_o), 0);
    check("postflush_empty", 32'(bus.empty_o), 1);

    // reset asserted mid-burst clears state immediately
    for (int i = 0; i < 3; i++) drive(1, 0, 0);
    drive(1, 1, 0);
    drive(1, 1, 0);
    check("burst_rd_valid", 32'(bus.rd_valid_o), 1);
    check("burst_count", 32'(bus.count_o), 3);
    rst = 1'b1;
    #1;
    check("midrst_count", 32'(bus.count_o), 0);
    check("midrst_empty", 32'(bus.empty_o), 1);
    check("midrst_wr_en", 32'(bus.mem_wr_en_o), 0);
    check("midrst_rd_en", 32'(bus.mem_rd_en_o), 0);
    check("midrst_rd_valid", 32'(bus.rd_valid_o), 0);
    check("midrst_wr_addr", 32'(bus.mem_wr_addr_o), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.push_i = 1'b0;
    bus.pop_i  = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Single-clock controller that sequences an external dual-port 8-bit memory as a FIFO of DEPTH entries.
- Owns write and read pointers, occupancy count, full/empty flags and sticky error flags.
- Drives the memory's write/read enables and addresses.
- Issues a read-valid strobe aligned to the memory's one-cycle registered read data.
- Sits between producer/consumer logic and the storage array; the data path bypasses the controller.

Parameters:
DEPTH, 8, number of memory entries; must equal 2**AW.
AW, 3, address width.
AF_THRESH, 6, almost-full threshold; used only with the optional feature.
AE_THRESH, 2, almost-empty threshold; used only with the optional feature.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst_i  input  1  asynchronous, active-high reset.
push_i  input  1  producer write request.
pop_i  input  1  consumer read request.
flush_i  input  1  synchronous clear of FIFO state.
mem_wr_en_o  output  1  memory write enable (combinational).
mem_wr_addr_o  output  AW  memory write address (combinational).
mem_rd_en_o  output  1  memory read enable (combinational).
mem_rd_addr_o  output  AW  memory read address (combinational).
rd_valid_o  output  1  memory read data valid this cycle.
full_o  output  1  count == DEPTH.
empty_o  output  1  count == 0.
count_o  output  AW+1  current occupancy, 0..DEPTH.
overflow_o  output  1  sticky: push refused.
underflow_o  output  1  sticky: pop refused.
almost_full_o  output  1  count >= AF_THRESH (optional feature).
almost_empty_o  output  1  count <= AE_THRESH (optional feature).

Behaviour:
- Reset (async, rst_i=1):
  - wr_ptr, rd_ptr, count = 0; rd_valid_o, overflow_o, underflow_o = 0.
  - empty_o = 1; full_o = 0.
  - Memory enables are 0 while reset is held.
- Accept rules (evaluated on current-cycle state):
  - wr_acc = push_i & (~full_o | pop_i).
  - rd_acc = pop_i & ~empty_o.
  - Full with push and pop together: both accepted, count unchanged.
  - Empty with push and pop together: only the push is accepted, count +1, and underflow_o is set.
- Memory drive:
  - mem_wr_en_o = wr_acc, mem_wr_addr_o = wr_ptr.
  - mem_rd_en_o = rd_acc, mem_rd_addr_o = rd_ptr.
  - The memory captures on the same clock edge.
- Pointers:
  - Each pointer increments by 1 on its accept, modulo DEPTH; it wraps from DEPTH-1 to 0 with no gap.
- Count:
  - +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- rd_valid_o:
  - Registered; equals rd_acc delayed by exactly 1 cycle, which is the memory read latency.
- overflow_o:
  - Set on push_i & full_o & ~pop_i.
  - Held until reset or flush.
- underflow_o:
  - Set on pop_i & empty_o.
  - Held until reset or flush.
- Flush:
  - flush_i=1 takes priority over push/pop in the same cycle. Accepts are forced to 0 and the memory enables stay low.
  - On the next edge: pointers and count = 0, error flags cleared, rd_valid_o = 0.
- Reset mid-operation:
  - Immediate clear of all state; no memory enable asserts while rst_i is high.
  - Memory contents are not cleared and are don't-care.
- Flag timing:
  - full_o and empty_o are derived from registered count, so they update one edge after an accept.

Optional Feature:
- Macro FIFO_CTRL_ALMOST_EN.
- Defined:
  - almost_full_o = (count >= AF_THRESH); almost_empty_o = (count <= AE_THRESH).
  - Both are combinational from the registered count.
- Undefined:
  - Both ports remain present and are tied to 0.
  - AF_THRESH and AE_THRESH are unused.

Test Plan:
1. Reset then idle -> empty_o=1, full_o=0, count_o=0, all enables 0, error flags 0.
2. Push 8 values with pop_i=0 -> mem_wr_addr_o runs 0..7; full_o=1 after the 8th edge. A 9th push sets overflow_o=1, wr_en stays 0, count stays 8.
3. From full, pop 8 -> mem_rd_addr_o runs 0..7; rd_valid_o follows each pop by 1 cycle; empty_o=1 after the last pop. A 9th pop sets underflow_o=1 with no rd_en.
4. Push 5, pop 5, then push 6 -> write addresses 5,6,7,0,1,2 (wrap); count_o=6. With the macro defined, almost_full_o=1 and almost_empty_o=0.
5. At count=8, push and pop asserted together for 3 cycles -> both enables high each cycle, count stays 8, no overflow. At count=0, push+pop together -> only the write occurs, count=1, underflow_o=1.
6. At count=4 with overflow_o=1, assert flush_i together with push_i -> no enables that cycle. Next cycle count=0, pointers=0, overflow_o=0. Assert rst_i mid-burst -> all outputs return to reset values immediately.
